mole_arena: RTL
===============

MOLE_ARENA -- requirements
Module: mole_arena

Interface
REQ-001 Parameter NUM_MOLES, default 18, number of mole slots / LEDs / switches.
REQ-002 Parameter MAX_MS, default 2047, ceiling of any millisecond timer; TW = $clog2(MAX_MS+1).
REQ-003 Parameter LIFE_MS, default 1500, base mole up-time in ms at level 0.
REQ-004 Parameter MIN_GAP_MS, default 200, minimum ms between spawn attempts.
REQ-005 Parameter MAX_ACTIVE, default 3, maximum moles up simultaneously.
REQ-006 Parameter MAX_MISSES, default 10, expired moles that end a game.
REQ-007 Parameter SCORE_W, default 11, score width.
REQ-008 clk  in  1  system clock; one clock domain, reset is synchronous and active-high.
REQ-009 reset  in  1  synchronous active-high reset.
REQ-010 start  in  1  one-cycle pulse, debounced; starts or restarts a game.
REQ-011 tick_ms  in  1  one-cycle strobe every 1 ms.
REQ-012 level  in  2  difficulty 0..3.
REQ-013 rand_value  in  16  free-running random word.
REQ-014 sw_pressed  in  NUM_MOLES  one-cycle debounced press pulses, bit i = mole i.
REQ-015 moles_up  out  NUM_MOLES  LED drive, bit i high while mole i is up.
REQ-016 score  out  SCORE_W  moles hit this game.
REQ-017 misses  out  $clog2(MAX_MISSES+1)  moles expired unhit this game.
REQ-018 hit_pulse  out  1  one-cycle pulse per cycle in which at least one hit was scored.
REQ-019 game_over  out  1  high in GAME_OVER state.

Function
REQ-020 FSM states IDLE, PLAYING, GAME_OVER; start in any state SHALL clear score, misses, moles_up, reload spawn timer, enter PLAYING next cycle.
REQ-021 PLAYING -> GAME_OVER in the cycle after misses reaches MAX_MISSES; moles_up cleared on entry; GAME_OVER held until start or reset.
REQ-022 In IDLE and GAME_OVER, sw_pressed, tick_ms, rand_value SHALL have no effect.
REQ-023 Spawn timer loads min(MAX_MS, (rand_value[10:0] >> level) + MIN_GAP_MS) and decrements on tick_ms.
REQ-024 On tick_ms with spawn timer = 1: candidate = rand_value[15:11] (low $clog2(NUM_MOLES) bits); spawn iff candidate < NUM_MOLES, that mole is down, and active count < MAX_ACTIVE; else attempt skipped; timer reloads either way.
REQ-025 Spawned mole lifetime counter loads LIFE_MS >> level; level sampled at spawn, later level changes do not affect live moles.
REQ-026 Live mole lifetime decrements on tick_ms; reaching 0 drops the mole and increments misses by 1 per expiring mole, same cycle.
REQ-027 sw_pressed[i] while mole i up: mole drops, score +1 per hit mole, hit_pulse high next cycle; outputs update one cycle after the press.
REQ-028 sw_pressed[i] while mole i down: ignored, no penalty.
REQ-029 Hit and expiry of the same mole in the same cycle: hit wins, no miss counted.
REQ-030 Multiple simultaneous hits/expiries SHALL each count (score and misses add popcounts).
REQ-031 score saturates at 2^SCORE_W-1; misses saturates at MAX_MISSES.

Reset
REQ-032 reset SHALL force IDLE, moles_up=0, score=0, misses=0, hit_pulse=0, game_over=0, all timers 0; reset wins over start in the same cycle.
REQ-033 reset mid-game SHALL abandon the game with no score/miss update from that cycle's inputs.

Structure
REQ-034 Package mole_pkg holds the state enum (IDLE, PLAYING, GAME_OVER), level_t (2-bit), and default constants.
REQ-035 Sub-module mole_slot: one mole's up flag and lifetime counter with spawn/hit/tick inputs and hit/expire outputs; instantiated NUM_MOLES times via generate.
REQ-036 Top holds FSM, spawn timer, active count, score/miss accumulation.

Verification
REQ-037 reset, start, level 0, rand_value=16'h0800 (candidate 1, gap 200) -> mole 1 up after 200 ticks, lifetime 1500.
REQ-038 Mole 1 up, sw_pressed[1] pulse -> moles_up[1]=0, score=1, hit_pulse one cycle, all one cycle later.
REQ-039 Level 3, no presses, MAX_MISSES=10 -> each mole expires after 187 ticks; game_over after 10th miss, moles_up=0.
REQ-040 sw_pressed[1] and mole 1 expiry on the same tick -> score +1, misses unchanged.
REQ-041 3 moles up, MAX_ACTIVE=3, spawn attempt on free candidate -> skipped, timer reloads; candidate 31 with NUM_MOLES=18 -> skipped.
REQ-042 start during GAME_OVER with score=5 -> score=0, misses=0, PLAYING next cycle; start and reset together -> IDLE.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared types and default constants for the whack-a-mole arena.
package mole_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PLAYING   = 2'd1,
      GAME_OVER = 2'd2
   } state_t;

   typedef logic [1:0] level_t;

   localparam int DEF_NUM_MOLES  = 18;
   localparam int DEF_MAX_MS     = 2047;
   localparam int DEF_LIFE_MS    = 1500;
   localparam int DEF_MIN_GAP_MS = 200;
   localparam int DEF_MAX_ACTIVE = 3;
   localparam int DEF_MAX_MISSES = 10;
   localparam int DEF_SCORE_W    = 11;

endpackage

// File: rtl/mole_if.sv
// Game-side bundle of the arena: player/timebase inputs and LED/score outputs.
// There is no valid/ready handshake: start, tick_ms and sw_pressed are
// single-cycle strobes that are acted on in the cycle they are high, and every
// output is a registered level that is valid in every cycle.
interface mole_if
   import mole_pkg::*;
#(
   parameter int NUM_MOLES = DEF_NUM_MOLES,
   parameter int SCORE_W   = DEF_SCORE_W,
   parameter int MISS_W    = $clog2(DEF_MAX_MISSES + 1)
) ();

   logic                 start;
   logic                 tick_ms;
   level_t               level;
   logic [15:0]          rand_value;
   logic [NUM_MOLES-1:0] sw_pressed;
   logic [NUM_MOLES-1:0] moles_up;
   logic [SCORE_W-1:0]   score;
   logic [MISS_W-1:0]    misses;
   logic                 hit_pulse;
   logic                 game_over;
   state_t               dbg_state;

   modport master (
      output start, tick_ms, level, rand_value, sw_pressed,
      input  moles_up, score, misses, hit_pulse, game_over, dbg_state
   );

   modport slave (
      input  start, tick_ms, level, rand_value, sw_pressed,
      output moles_up, score, misses, hit_pulse, game_over, dbg_state
   );

endinterface

// File: rtl/mole_slot.sv
// One mole: up flag plus lifetime counter. A hit takes priority over expiry.
module mole_slot #(
   parameter int TW = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_clr,
   input  logic          i_spawn,
   input  logic [TW-1:0] i_life,
   input  logic          i_tick,
   input  logic          i_press,
   output logic          o_up,
   output logic          o_hit,
   output logic          o_expire
);

   logic          r_up;
   logic [TW-1:0] r_life;

   assign o_up     = r_up;
   assign o_hit    = r_up & i_press;
   assign o_expire = r_up & i_tick & (r_life <= TW'(1)) & ~i_press;

   // Spawn loads the lifetime; ticks count it down; hit or expiry drops the mole.
   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_up   <= 1'b0;
         r_life <= '0;
      end else if (o_hit || o_expire) begin
         r_up   <= 1'b0;
         r_life <= '0;
      end else if (i_spawn) begin
         r_up   <= 1'b1;
         r_life <= i_life;
      end else if (r_up && i_tick) begin
         r_life <= r_life - TW'(1);
      end
   end

endmodule

// File: rtl/mole_arena.sv
// Arena top: game FSM, spawn timer, mole slots, score and miss accumulation.
module mole_arena
   import mole_pkg::*;
#(
   parameter int NUM_MOLES  = DEF_NUM_MOLES,
   parameter int MAX_MS     = DEF_MAX_MS,
   parameter int LIFE_MS    = DEF_LIFE_MS,
   parameter int MIN_GAP_MS = DEF_MIN_GAP_MS,
   parameter int MAX_ACTIVE = DEF_MAX_ACTIVE,
   parameter int MAX_MISSES = DEF_MAX_MISSES,
   parameter int SCORE_W    = DEF_SCORE_W
) (
   input logic  clk,
   input logic  reset,
   mole_if.slave bus
);

   localparam int TW     = $clog2(MAX_MS + 1);
   localparam int CW     = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
   localparam int MISS_W = $clog2(MAX_MISSES + 1);
   localparam int PW     = $clog2(NUM_MOLES + 1);
   localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

   state_t               r_state, w_state_nxt;
   logic [TW-1:0]        r_spawn_tmr;
   logic [SCORE_W-1:0]   r_score;
   logic [MISS_W-1:0]    r_misses;
   logic                 r_hit_pulse;

   logic                 w_playing, w_run, w_clr, w_tick, w_attempt;
   logic                 w_cand_free, w_spawn_ok;
   logic [CW-1:0]        w_cand;
   logic [TW-1:0]        w_gap, w_life;
   logic [31:0]          w_gap_sum, w_score_sum, w_miss_sum;
   logic [PW-1:0]        w_n_up, w_n_hit, w_n_exp;
   logic [NUM_MOLES-1:0] w_up, w_hit, w_exp, w_spawn_vec;

   // Moles only move while playing and before the final miss closes the game.
   assign w_playing = (r_state == PLAYING);
   assign w_run     = w_playing && (r_misses < MISS_W'(MAX_MISSES)) && !bus.start;
   assign w_clr     = bus.start || (w_playing && (r_misses >= MISS_W'(MAX_MISSES)));
   assign w_tick    = w_run && bus.tick_ms;
   assign w_attempt = w_tick && (r_spawn_tmr == TW'(1));
   assign w_cand    = bus.rand_value[11 +: CW];

   // Gap between spawn attempts shrinks with level and is capped at MAX_MS.
   assign w_gap_sum = 32'(bus.rand_value[10:0] >> bus.level) + 32'(MIN_GAP_MS);
   assign w_gap     = (w_gap_sum > 32'(MAX_MS)) ? TW'(MAX_MS) : TW'(w_gap_sum);
   assign w_life    = TW'(LIFE_MS >> bus.level);

   // Popcounts of live, hit and expiring moles plus candidate decode.
   always_comb begin
      w_n_up      = '0;
      w_n_hit     = '0;
      w_n_exp     = '0;
      w_cand_free = 1'b0;
      for (int i = 0; i < NUM_MOLES; i++) begin
         w_n_up  = w_n_up  + PW'(w_up[i]);
         w_n_hit = w_n_hit + PW'(w_hit[i]);
         w_n_exp = w_n_exp + PW'(w_exp[i]);
         if (CW'(i) == w_cand) w_cand_free = !w_up[i];
      end
   end

   assign w_spawn_ok = w_attempt && w_cand_free && (w_n_up < PW'(MAX_ACTIVE));

   // One-hot spawn request to the chosen slot.
   always_comb begin
      w_spawn_vec = '0;
      for (int i = 0; i < NUM_MOLES; i++) begin
         w_spawn_vec[i] = w_spawn_ok && (CW'(i) == w_cand);
      end
   end

   for (genvar g = 0; g < NUM_MOLES; g++) begin : g_slot
      mole_slot #(.TW(TW)) u_slot (
         .clk      (clk),
         .reset    (reset),
         .i_clr    (w_clr),
         .i_spawn  (w_spawn_vec[g]),
         .i_life   (w_life),
         .i_tick   (w_tick),
         .i_press  (w_run && bus.sw_pressed[g]),
         .o_up     (w_up[g]),
         .o_hit    (w_hit[g]),
         .o_expire (w_exp[g])
      );
   end

   // Game state register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state: start always (re)enters PLAYING; the last miss ends the game.
   always_comb begin
      w_state_nxt = r_state;
      if (bus.start) begin
         w_state_nxt = PLAYING;
      end else begin
         case (r_state)
            PLAYING: if (r_misses >= MISS_W'(MAX_MISSES)) w_state_nxt = GAME_OVER;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   // Spawn timer: reload on start and on every attempt, otherwise count ticks.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_spawn_tmr <= '0;
      end else if (bus.start) begin
         r_spawn_tmr <= w_gap;
      end else if (w_tick) begin
         if (r_spawn_tmr == TW'(1))   r_spawn_tmr <= w_gap;
         else if (r_spawn_tmr != '0)  r_spawn_tmr <= r_spawn_tmr - TW'(1);
      end
   end

   assign w_score_sum = 32'(r_score)  + 32'(w_n_hit);
   assign w_miss_sum  = 32'(r_misses) + 32'(w_n_exp);

   // Saturating score/miss accumulation and the registered hit strobe.
   always_ff @(posedge clk) begin
      if (reset || bus.start) begin
         r_score     <= '0;
         r_misses    <= '0;
         r_hit_pulse <= 1'b0;
      end else begin
         r_hit_pulse <= |w_hit;
         if (w_run) begin
            r_score  <= (w_score_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(w_score_sum);
            r_misses <= (w_miss_sum > 32'(MAX_MISSES)) ? MISS_W'(MAX_MISSES) : MISS_W'(w_miss_sum);
         end
      end
   end

   assign bus.moles_up  = w_up;
   assign bus.score     = r_score;
   assign bus.misses    = r_misses;
   assign bus.hit_pulse = r_hit_pulse;
   assign bus.game_over = (r_state == GAME_OVER);
   assign bus.dbg_state = r_state;

endmodule
